// File: rtl/core_timer_multi.sv
// core_timer_multi: NUM_CH independent down-counting interval timers behind one Avalon-MM slave.
// Optional feature macro TIMER_PWM_EN adds per-channel compare registers and a registered pwm_out.

module core_timer_multi #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 39999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned HI_W = CNT_W - 16;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_CMP_L    = 3'd6,
    REG_CMP_H    = 3'd7
  } reg_e;

  typedef struct packed {
    logic             to;
    logic             run;
    logic             ito;
    logic             cont;
    logic             force_reload;
    logic             zero_prev;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] snap;
  } chan_t;

  localparam chan_t CH_RST = '{
    to:           1'b0,
    run:          1'b0,
    ito:          1'b0,
    cont:         1'b0,
    force_reload: 1'b0,
    zero_prev:    (RESET_PERIOD == 0),
    period:       CNT_W'(RESET_PERIOD),
    cnt:          CNT_W'(RESET_PERIOD),
    snap:         '0
  };

  logic [1:0]              acc_ch;
  reg_e                    acc_reg;
  logic                    bus_wr;
  logic                    bus_rd;
  logic [NUM_CH-1:0][15:0] rd_vec;
  logic [15:0]             rd_mux;
  logic [15:0]             readdata_q;

  assign acc_ch  = address[4:3];
  assign acc_reg = reg_e'(address[2:0]);
  assign bus_wr  = chipselect && !write_n;
  assign bus_rd  = chipselect && write_n;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    chan_t       st_q, st_d;
    logic        sel_wr;
    logic        zero;
    logic        timeout;
    logic [15:0] rd_val;

    assign sel_wr  = bus_wr && (acc_ch == 2'(ch));
    assign zero    = (st_q.cnt == '0);
    // Timeout is the rising edge of zero so a counter parked at 0 fires only once.
    assign timeout = zero && !st_q.zero_prev;

`ifdef TIMER_PWM_EN
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             pwm_q;

    always_comb begin
      cmp_d = cmp_q;
      if (sel_wr && acc_reg == REG_CMP_L) cmp_d[15:0]       = writedata;
      if (sel_wr && acc_reg == REG_CMP_H) cmp_d[CNT_W-1:16] = writedata[HI_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cmp_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        pwm_q <= st_q.run && (st_q.cnt <= cmp_q);
      end
    end

    assign pwm_out[ch] = pwm_q;
`else
    assign pwm_out[ch] = 1'b0;
`endif

    always_comb begin
      // NOTE: every field gets its default from st_q first, so no path through the case leaves st_d unassigned and no latch is inferred.
      st_d              = st_q;
      st_d.zero_prev    = zero;
      st_d.force_reload = sel_wr && (acc_reg == REG_PERIOD_L || acc_reg == REG_PERIOD_H);

      if (st_q.run) begin
        if (!zero)             st_d.cnt = st_q.cnt - CNT_W'(1);
        else if (st_q.cont)    st_d.cnt = st_q.period;
        else                   st_d.run = 1'b0;
      end

      if (st_q.force_reload) begin
        st_d.cnt = st_q.period;
        st_d.run = 1'b0;
      end

      if (sel_wr) begin
        case (acc_reg)
          REG_STATUS: st_d.to = 1'b0;
          REG_CONTROL: begin
            st_d.ito  = writedata[0];
            st_d.cont = writedata[1];
            // START outranks STOP; restarting a spent one-shot reloads from PERIOD.
            if (writedata[2]) begin
              st_d.run = 1'b1;
              if (!st_q.run && zero) st_d.cnt = st_q.period;
            end else if (writedata[3]) begin
              st_d.run = 1'b0;
            end
          end
          REG_PERIOD_L: st_d.period[15:0]       = writedata;
          REG_PERIOD_H: st_d.period[CNT_W-1:16] = writedata[HI_W-1:0];
          REG_SNAP_L,
          REG_SNAP_H:   st_d.snap = st_q.cnt;
          default: ;
        endcase
      end

      // A timeout in the same cycle as a STATUS write keeps TO set.
      if (timeout) st_d.to = 1'b1;
    end

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset_n) st_q <= CH_RST;
      else          st_q <= st_d;
    end

    always_comb begin
      rd_val = '0;
      case (acc_reg)
        REG_STATUS:   rd_val[1:0]      = {st_q.run, st_q.to};
        REG_CONTROL:  rd_val[1:0]      = {st_q.cont, st_q.ito};
        REG_PERIOD_L: rd_val           = st_q.period[15:0];
        REG_PERIOD_H: rd_val[HI_W-1:0] = st_q.period[CNT_W-1:16];
        REG_SNAP_L:   rd_val           = st_q.snap[15:0];
        REG_SNAP_H:   rd_val[HI_W-1:0] = st_q.snap[CNT_W-1:16];
`ifdef TIMER_PWM_EN
        REG_CMP_L:    rd_val           = cmp_q[15:0];
        REG_CMP_H:    rd_val[HI_W-1:0] = cmp_q[CNT_W-1:16];
`endif
        default: ;
      endcase
    end

    assign rd_vec[ch]  = rd_val;
    assign irq_vec[ch] = st_q.to && st_q.ito;
  end

  // Channels at or above NUM_CH never match and read back 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_ch == 2'(i)) rd_mux = rd_vec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)    readdata_q <= '0;
    else if (bus_rd) readdata_q <= rd_mux;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_core_timer_multi.sv
// Directed bench for core_timer_multi (CNT_W=20); read results flow through an expected-value queue.
// Works with or without TIMER_PWM_EN; the PWM expectations follow the macro.

module tb_core_timer_multi;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 20;
  localparam int RESET_PERIOD = 39999;

`ifdef TIMER_PWM_EN
  localparam int          PWM_HIGH_EXP = 6;
  localparam logic [15:0] CMP_L_EXP    = 16'h0002;
`else
  localparam int          PWM_HIGH_EXP = 0;
  localparam logic [15:0] CMP_L_EXP    = 16'h0000;
`endif

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic [4:0]        address    = '0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic [15:0]       writedata  = '0;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
  logic [NUM_CH-1:0] pwm_out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  core_timer_multi #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .pwm_out    (pwm_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [15:0] d);
    address    = {2'(ch), 3'(r)};
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input int ch, input int r, input logic [15:0] exp);
    address    = {2'(ch), 3'(r)};
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(exp);
    tick(1);
    chipselect = 1'b0;
    check(tag, 32'(readdata), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int pwm_high;

    // Reset state
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("reset readdata", 32'(readdata), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset irq_vec", 32'(irq_vec), 32'h0);
    check("reset pwm_out", 32'(pwm_out), 32'h0);
    rd("reset ch0 period_l", 0, 2, 16'h9C3F);
    rd("reset ch0 period_h", 0, 3, 16'h0000);
    rd("reset ch0 status", 0, 0, 16'h0000);
    rd("reset ch0 control", 0, 1, 16'h0000);
    rd("reset ch1 snap_l", 1, 4, 16'h0000);

    // Ch1 one-shot, period 9, ITO on
    wr(1, 2, 16'd9);
    wr(1, 3, 16'd0);
    tick(1);
    wr(1, 1, 16'h0005);
    rd("ch1 run after start", 1, 0, 16'h0002);
    tick(8);
    check("ch1 irq_vec before timeout", 32'(irq_vec), 32'h0);
    tick(1);
    check("ch1 irq_vec at timeout", 32'(irq_vec), 32'h2);
    check("ch1 irq at timeout", 32'(irq), 32'h1);
    rd("ch1 status after one-shot", 1, 0, 16'h0001);
    tick(3);
    wr(1, 4, 16'h0);
    rd("ch1 counter holds 0 lo", 1, 4, 16'h0000);
    rd("ch1 counter holds 0 hi", 1, 5, 16'h0000);
    wr(1, 0, 16'h0);
    check("ch1 irq_vec after clear", 32'(irq_vec), 32'h0);
    check("ch1 irq after clear", 32'(irq), 32'h0);

    // Ch0 continuous, period 4: events every 5 cycles
    wr(0, 2, 16'd4);
    wr(0, 3, 16'd0);
    tick(1);
    wr(0, 1, 16'h0006);
    tick(4);
    rd("ch0 status before event", 0, 0, 16'h0002);
    rd("ch0 status after event", 0, 0, 16'h0003);
    check("ch0 irq masked by ito", 32'(irq), 32'h0);
    wr(0, 0, 16'h0);
    rd("ch0 status cleared", 0, 0, 16'h0002);
    tick(1);
    wr(0, 0, 16'h0);
    rd("ch0 status write on event keeps TO", 0, 0, 16'h0003);
    wr(0, 0, 16'h0);
    rd("ch0 status cleared again", 0, 0, 16'h0002);
    tick(2);
    wr(0, 0, 16'h0);
    rd("ch0 status write one cycle late clears", 0, 0, 16'h0002);
    wr(0, 1, 16'h0008);

    // Snapshot and width with CNT_W=20
    wr(1, 3, 16'hFFFF);
    rd("ch1 period_h truncated", 1, 3, 16'h000F);
    wr(1, 1, 16'h0004);
    tick(3);
    wr(1, 4, 16'h0);
    rd("ch1 snap_l", 1, 4, 16'h0006);
    rd("ch1 snap_h", 1, 5, 16'h000F);

    // Period write mid-run, then START+STOP together
    wr(1, 2, 16'h0020);
    rd("ch1 running before reload", 1, 0, 16'h0002);
    rd("ch1 stopped by period write", 1, 0, 16'h0000);
    wr(1, 4, 16'h0);
    rd("ch1 reloaded snap_l", 1, 4, 16'h0020);
    rd("ch1 reloaded snap_h", 1, 5, 16'h000F);
    wr(1, 1, 16'h000C);
    rd("ch1 start wins over stop", 1, 0, 16'h0002);
    rd("ch1 control start/stop read 0", 1, 1, 16'h0000);
    wr(1, 1, 16'h0008);
    rd("ch1 stopped", 1, 0, 16'h0000);

    // PWM: period 9, cmp 2, continuous
    wr(0, 2, 16'd9);
    wr(0, 3, 16'd0);
    wr(0, 6, 16'd2);
    wr(0, 7, 16'd0);
    wr(0, 1, 16'h0006);
    tick(3);
    pwm_high = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (pwm_out[0]) pwm_high++;
    end
    check("pwm ch0 high cycles in 20", 32'(pwm_high), 32'(PWM_HIGH_EXP));
    check("pwm ch1 idle", 32'(pwm_out[1]), 32'h0);
    rd("ch0 cmp_l", 0, 6, CMP_L_EXP);
    rd("ch0 cmp_h", 0, 7, 16'h0000);

    // Channels beyond NUM_CH
    wr(3, 2, 16'h0005);
    rd("ch3 period_l reads 0", 3, 2, 16'h0000);
    rd("ch2 control reads 0", 2, 1, 16'h0000);

    // Reset while ch0 counts
    rd("ch0 period_l before reset", 0, 2, 16'd9);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid reset readdata", 32'(readdata), 32'h0);
    check("mid reset irq_vec", 32'(irq_vec), 32'h0);
    check("mid reset pwm_out", 32'(pwm_out), 32'h0);
    rd("mid reset ch0 status", 0, 0, 16'h0000);
    rd("mid reset ch0 period_l", 0, 2, 16'h9C3F);
    rd("mid reset ch0 control", 0, 1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
